// File: rtl/stream_prefix_xor_decoder_if.sv
// Stream bus for the prefix-XOR decoder.
// master = the side that offers encoded beats and consumes decoded beats.
// slave  = the decoder itself.
interface stream_prefix_xor_decoder_if #(
    parameter int p_WIDTH     = 8,
    parameter int p_MAX_BEATS = 16
);
    localparam int CW = $clog2(p_MAX_BEATS + 1);

    logic [p_WIDTH-1:0] iwv_data;
    logic               iw_valid;
    logic               iw_last;
    logic               iw_ready;
    logic [p_WIDTH-1:0] owv_data;
    logic               ow_valid;
    logic               ow_last;
    logic               iw_out_ready;
    logic [CW-1:0]      owv_beat_count;
    logic               ow_overlength;

    modport slave (
        input  iwv_data, iw_valid, iw_last, iw_out_ready,
        output iw_ready, owv_data, ow_valid, ow_last, owv_beat_count, ow_overlength
    );

    modport master (
        output iwv_data, iw_valid, iw_last, iw_out_ready,
        input  iw_ready, owv_data, ow_valid, ow_last, owv_beat_count, ow_overlength
    );
endinterface

// File: rtl/stream_prefix_xor_decoder.sv
// Streaming decoder that inverts a prefix XOR running across the beats of a
// packet. There is one output register with a skid-free ready: a new beat is
// accepted whenever the output slot is empty or is draining this cycle.
module stream_prefix_xor_decoder #(
    parameter int p_WIDTH     = 8,
    parameter int p_MAX_BEATS = 16
) (
    input  logic i_clk,
    input  logic i_reset,
    stream_prefix_xor_decoder_if.slave bus
);
    localparam int            CW   = $clog2(p_MAX_BEATS + 1);
    localparam logic [CW-1:0] MAXC = CW'(p_MAX_BEATS);

    typedef enum logic {IDLE, IN_PKT} state_t;

    state_t             state_q, state_d;
    logic               carry_q, carry_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               ovl_q, ovl_d;
    logic [p_WIDTH-1:0] data_q, data_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;

    logic               ready;
    logic               accept;
    logic               cin;
    logic [p_WIDTH-1:0] decoded;

    assign ready  = !valid_q || bus.iw_out_ready;
    assign accept = bus.iw_valid && ready;

    // The carry only applies inside a packet; the first beat always sees 0.
    assign cin     = (state_q == IN_PKT) && carry_q;
    assign decoded = bus.iwv_data ^ {bus.iwv_data[p_WIDTH-2:0], cin};

    // State register; reset drops any held beat and the packet context.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            ovl_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            ovl_q   <= ovl_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    // Next-state: output slot refill/hold, packet tracking, beat count and overflow flag.
    always_comb begin
        state_d = state_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        ovl_d   = ovl_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;

        // Output slot only changes when it is free or being drained.
        if (ready) begin
            valid_d = accept;
            if (accept) begin
                data_d = decoded;
                last_d = bus.iw_last;
            end
        end

        if (accept) begin
            if (cnt_q == MAXC) ovl_d = 1'b1;
            if (bus.iw_last) begin
                state_d = IDLE;
                carry_d = 1'b0;
                cnt_d   = '0;
            end else begin
                state_d = IN_PKT;
                carry_d = bus.iwv_data[p_WIDTH-1];
                if (cnt_q != MAXC) cnt_d = cnt_q + CW'(1);
            end
        end
    end

    assign bus.iw_ready       = ready;
    assign bus.owv_data       = data_q;
    assign bus.ow_valid       = valid_q;
    assign bus.ow_last        = last_q;
    assign bus.owv_beat_count = cnt_q;
    assign bus.ow_overlength  = ovl_q;
endmodule

// File: tb/tb_stream_prefix_xor_decoder.sv
// Scoreboard bench for stream_prefix_xor_decoder (p_WIDTH=8, p_MAX_BEATS=4).
// Inputs change 1 time unit after the rising edge; everything is sampled on
// the falling edge.
module tb_stream_prefix_xor_decoder;
    localparam int W  = 8;
    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stream_prefix_xor_decoder_if #(.p_WIDTH(W), .p_MAX_BEATS(MB)) bus ();

    stream_prefix_xor_decoder #(.p_WIDTH(W), .p_MAX_BEATS(MB)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    typedef struct packed {
        logic [W-1:0] d;
        logic         l;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   rnd_rdy = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every output transfer pops one expected beat.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.ow_valid && bus.iw_out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got %02h expected none", bus.owv_data);
            end else begin
                e = sb.pop_front();
                chk("out_data", int'(bus.owv_data), int'(e.d));
                chk("out_last", int'(bus.ow_last), int'(e.l));
            end
        end
    end

    // Random downstream backpressure, enabled only for the random stream.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_rdy) bus.iw_out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one beat and wait (bounded) until it is accepted.
    task automatic send(input logic [W-1:0] d, input logic l, input logic [W-1:0] e);
        bit ok;
        ok = 1'b0;
        sb.push_back({e, l});
        bus.iw_valid = 1'b1;
        bus.iwv_data = d;
        bus.iw_last  = l;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (bus.iw_ready) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (ok) step();
        else begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no accept expected accept of %02h", d);
        end
        bus.iw_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.iw_valid = 1'b0;
        sb.delete();
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [W-1:0] o, e;
        logic         c;
        int           len;

        bus.iw_valid     = 1'b0;
        bus.iwv_data     = '0;
        bus.iw_last      = 1'b0;
        bus.iw_out_ready = 1'b1;
        step();
        do_reset();

        // Reset state
        @(negedge clk);
        chk("rst_valid", int'(bus.ow_valid), 0);
        chk("rst_data", int'(bus.owv_data), 0);
        chk("rst_count", int'(bus.owv_beat_count), 0);
        chk("rst_ovl", int'(bus.ow_overlength), 0);
        chk("rst_ready", int'(bus.iw_ready), 1);
        step();

        // Single-beat packet, one-cycle latency
        send(8'h0F, 1'b1, 8'h11);
        @(negedge clk);
        chk("single_latency_valid", int'(bus.ow_valid), 1);
        chk("single_count", int'(bus.owv_beat_count), 0);
        step();

        // Carry across beats, then cleared for the next packet
        send(8'hFF, 1'b0, 8'h01);
        @(negedge clk);
        chk("pkt_count1", int'(bus.owv_beat_count), 1);
        step();
        send(8'h00, 1'b1, 8'h01);
        send(8'h00, 1'b1, 8'h00);
        @(negedge clk);
        chk("pkt_count_end", int'(bus.owv_beat_count), 0);
        step();

        // Downstream stall for 3 cycles with one beat held
        bus.iw_out_ready = 1'b0;
        send(8'h3C, 1'b1, 8'h44);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_ready", int'(bus.iw_ready), 0);
            chk("stall_valid", int'(bus.ow_valid), 1);
            chk("stall_data", int'(bus.owv_data), 8'h44);
            step();
        end
        bus.iw_out_ready = 1'b1;
        step();
        @(negedge clk);
        chk("stall_valid_drop", int'(bus.ow_valid), 0);
        chk("stall_sb_empty", sb.size(), 0);
        step();

        // Overlength: five beats with max four
        send(8'h80, 1'b0, 8'h80);
        send(8'h80, 1'b0, 8'h81);
        send(8'h80, 1'b0, 8'h81);
        send(8'h80, 1'b0, 8'h81);
        @(negedge clk);
        chk("ovl_count_sat", int'(bus.owv_beat_count), 4);
        chk("ovl_not_yet", int'(bus.ow_overlength), 0);
        step();
        send(8'h80, 1'b1, 8'h81);
        @(negedge clk);
        chk("ovl_set", int'(bus.ow_overlength), 1);
        chk("ovl_count_end", int'(bus.owv_beat_count), 0);
        step();
        send(8'h0F, 1'b1, 8'h11);
        @(negedge clk);
        chk("ovl_sticky", int'(bus.ow_overlength), 1);
        step();

        // Reset mid-packet discards carry and clears overlength
        send(8'hFF, 1'b0, 8'h01);
        step();
        do_reset();
        @(negedge clk);
        chk("midrst_ovl", int'(bus.ow_overlength), 0);
        chk("midrst_count", int'(bus.owv_beat_count), 0);
        step();
        send(8'h00, 1'b1, 8'h00);
        @(negedge clk);
        chk("midrst_ovl_after", int'(bus.ow_overlength), 0);
        step();

        // Reset during a stall drops the held beat
        bus.iw_out_ready = 1'b0;
        send(8'h55, 1'b0, 8'hFF);
        do_reset();
        bus.iw_out_ready = 1'b1;
        @(negedge clk);
        chk("stallrst_valid", int'(bus.ow_valid), 0);
        step();
        send(8'h00, 1'b1, 8'h00);
        step();

        // Random stream through a software prefix-XOR encoder
        rnd_rdy = 1'b1;
        for (int p = 0; p < 12; p++) begin
            len = $urandom_range(1, MB);
            c = 1'b0;
            for (int b = 0; b < len; b++) begin
                o = W'($urandom);
                for (int j = 0; j < W; j++) e[j] = o[j] ^ ((j == 0) ? c : e[j-1]);
                c = e[W-1];
                repeat ($urandom_range(0, 2)) step();
                send(e, (b == len - 1), o);
            end
        end
        rnd_rdy = 1'b0;
        step();
        bus.iw_out_ready = 1'b1;
        for (int n = 0; n < 50 && sb.size() != 0; n++) step();
        chk("drain_sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
